mips_multicycle_ctrl: RTL and testbench

Multi-cycle control unit for the MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives the ALU operation select and the datapath mux/enable controls, and consumes the ALU `zero` flag to resolve branches. It sits between the instruction register (source of `opcode`/`funct`) and the shared ALU/register-file/memory datapath.

---
 rtl/mips_multicycle_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
//   Multi-cycle control unit for a MIPS datapath. It steps each instruction
//   through fetch, decode, execute, memory and writeback. It drives the ALU
//   operation and the datapath mux/enable controls. It uses the ALU zero flag
//   to resolve beq.
//
// Ports
//   clk          : single clock, rising edge
//   reset_n      : asynchronous active-low reset (state -> IDLE, counter -> 0)
//   opcode/funct : instruction fields from the IR, valid from DECODE onward
//   zero         : ALU zero flag (branch condition)
//   mem_ready    : memory finishes the current read/write this cycle
//   alu_sel      : 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
//   alu_src_a    : 0 PC, 1 register A
//   alu_src_b    : 00 B, 01 const 4, 10 sext imm, 11 sext imm << 2
//   iord         : memory address source (0 PC, 1 ALU result register)
//   mem_read/mem_write, ir_write, reg_write, reg_dst, mem_to_reg
//   pc_src       : 00 ALU result, 01 ALU result register, 10 jump target
//   pc_en        : PC load enable
//   illegal      : one-cycle pulse on unsupported opcode/funct
//   instr_count  : number of completed fetches (wraps)

module mips_multicycle_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [2:0]  alu_sel,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic [1:0]  pc_src,
  output logic        pc_en,
  output logic        illegal,
  output logic [31:0] instr_count
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMRD    = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWR    = 4'd6,
    S_RTYPE_EX = 4'd7,
    S_RTYPE_WB = 4'd8,
    S_BEQ_EX   = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11,
    S_JUMP     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t      state;
  state_t      state_next;
  logic [31:0] instr_count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // One count per IR load. Natural 32-bit overflow gives the wrap to zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_count_q <= 32'd0;
    end else if (ir_write) begin
      instr_count_q <= instr_count_q + 32'd1;
    end
  end

  assign instr_count = instr_count_q;

  always_comb begin
    alu_sel    = 3'b000;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    pc_src     = 2'b00;
    pc_en      = 1'b0;
    illegal    = 1'b0;
    state_next = S_FETCH;

    case (state)
      S_IDLE: begin
        state_next = S_FETCH;
      end

      // The IR load and the PC+4 update both complete on the cycle the
      // memory returns the word. The read strobe stays up while waiting.
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_sel   = ALU_ADD;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        state_next = mem_ready ? S_DECODE : S_FETCH;
      end

      // The ALU is idle here, so it precomputes the beq target into the
      // ALU result register for use in BEQ_EX.
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_sel   = ALU_ADD;
        case (opcode)
          OP_RTYPE:     state_next = S_RTYPE_EX;
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_BEQ:       state_next = S_BEQ_EX;
          OP_ADDI:      state_next = S_ADDI_EX;
          OP_J:         state_next = S_JUMP;
          default: begin
            illegal    = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end

      // Only lw and sw reach this state. Anything that is not sw goes to
      // the read path.
      S_MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        alu_sel    = ALU_ADD;
        state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end

      S_MEMRD: begin
        mem_read   = 1'b1;
        iord       = 1'b1;
        state_next = mem_ready ? S_MEMWB : S_MEMRD;
      end

      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_next = S_FETCH;
      end

      S_MEMWR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        state_next = mem_ready ? S_FETCH : S_MEMWR;
      end

      // An unknown funct aborts the instruction without a writeback.
      S_RTYPE_EX: begin
        alu_src_a  = 1'b1;
        state_next = S_RTYPE_WB;
        case (funct)
          FN_ADD:  alu_sel = ALU_ADD;
          FN_SUB:  alu_sel = ALU_SUB;
          FN_AND:  alu_sel = ALU_AND;
          FN_OR:   alu_sel = ALU_OR;
          FN_SLT:  alu_sel = ALU_SLT;
          default: begin
            alu_sel    = ALU_ADD;
            illegal    = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end

      S_RTYPE_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        state_next = S_FETCH;
      end

      S_BEQ_EX: begin
        alu_src_a  = 1'b1;
        alu_sel    = ALU_SUB;
        pc_src     = 2'b01;
        pc_en      = zero;
        state_next = S_FETCH;
      end

      S_ADDI_EX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        alu_sel    = ALU_ADD;
        state_next = S_ADDI_WB;
      end

      S_ADDI_WB: begin
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end

      S_JUMP: begin
        pc_src     = 2'b10;
        pc_en      = 1'b1;
        state_next = S_FETCH;
      end

      // Unused encodings: every output stays at its default of zero, and
      // the next state is FETCH.
      default: begin
        state_next = S_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl
//   Self-checking bench for mips_multicycle_ctrl. Each instruction is expanded
//   into its expected cycle-by-cycle control pattern from the instruction-level
//   rules (fetch with stalls, decode, then a per-opcode sequence). Every cycle
//   is compared against the DUT.

module tb_mips_multicycle_ctrl;

  logic        clk;
  logic        reset_n;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ready;
  logic [2:0]  alu_sel;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        iord;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        reg_write;
  logic        reg_dst;
  logic        mem_to_reg;
  logic [1:0]  pc_src;
  logic        pc_en;
  logic        illegal;
  logic [31:0] instr_count;

  int          errors;
  int          checks;
  logic [31:0] exp_count;

  mips_multicycle_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .opcode      (opcode),
    .funct       (funct),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .alu_sel     (alu_sel),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .iord        (iord),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .reg_write   (reg_write),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .pc_src      (pc_src),
    .pc_en       (pc_en),
    .illegal     (illegal),
    .instr_count (instr_count)
  );

  // All 17 control bits packed, in the same order vec() takes its arguments.
  logic [16:0] obs_vec;
  assign obs_vec = {alu_sel, alu_src_a, alu_src_b, iord, mem_read, mem_write,
                    ir_write, reg_write, reg_dst, mem_to_reg, pc_src, pc_en,
                    illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [16:0] vec(
    input logic [2:0] as, input logic sa, input logic [1:0] sb,
    input logic io, input logic mr, input logic mw, input logic irw,
    input logic rw, input logic rd, input logic m2r,
    input logic [1:0] ps, input logic pe, input logic il);
    return {as, sa, sb, io, mr, mw, irw, rw, rd, m2r, ps, pe, il};
  endfunction

  function automatic bit is_legal_op(input logic [5:0] op);
    return (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
           (op == 6'b000100) || (op == 6'b001000) || (op == 6'b000010);
  endfunction

  function automatic bit is_legal_fn(input logic [5:0] fn);
    return (fn == 6'b100000) || (fn == 6'b100010) || (fn == 6'b100100) ||
           (fn == 6'b100101) || (fn == 6'b101010);
  endfunction

  function automatic logic [2:0] fn_to_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed,
               expected, $time);
    end
  endtask

  // Drives one cycle's inputs, checks the control pattern mid-cycle, then
  // advances to 1 time unit after the next rising edge.
  task automatic applyStimulus(input logic mr, input logic z,
                               input logic [16:0] exp_vec, input string tag);
    mem_ready = mr;
    zero      = z;
    #1;
    checkOutput(tag, {15'd0, obs_vec}, {15'd0, exp_vec});
    @(posedge clk);
    #1;
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(1, 0));
  endfunction

  // Instruction-level reference: fs/ms are stall cycles in fetch and in
  // the memory access, z is the branch condition seen in BEQ_EX.
  task automatic runInstr(input logic [5:0] op, input logic [5:0] fn,
                          input logic z, input int fs, input int ms);
    opcode = op;
    funct  = fn;
    for (int i = 0; i < fs; i++)
      applyStimulus(1'b0, rbit(), vec(3'b010, 0, 2'b01, 0, 1, 0, 0, 0, 0, 0,
                                      2'b00, 0, 0), "fetch_wait");
    applyStimulus(1'b1, rbit(), vec(3'b010, 0, 2'b01, 0, 1, 0, 1, 0, 0, 0,
                                    2'b00, 1, 0), "fetch");
    exp_count = exp_count + 32'd1;
    checkOutput("instr_count", instr_count, exp_count);
    applyStimulus(rbit(), rbit(), vec(3'b010, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0,
                                      2'b00, 0, !is_legal_op(op)), "decode");
    case (op)
      6'b100011: begin
        applyStimulus(rbit(), rbit(), vec(3'b010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0,
                                          2'b00, 0, 0), "lw_memadr");
        for (int i = 0; i < ms; i++)
          applyStimulus(1'b0, rbit(), vec(3'b000, 0, 2'b00, 1, 1, 0, 0, 0, 0, 0,
                                          2'b00, 0, 0), "memrd_wait");
        applyStimulus(1'b1, rbit(), vec(3'b000, 0, 2'b00, 1, 1, 0, 0, 0, 0, 0,
                                        2'b00, 0, 0), "memrd");
        applyStimulus(rbit(), rbit(), vec(3'b000, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1,
                                          2'b00, 0, 0), "memwb");
      end
      6'b101011: begin
        applyStimulus(rbit(), rbit(), vec(3'b010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0,
                                          2'b00, 0, 0), "sw_memadr");
        for (int i = 0; i < ms; i++)
          applyStimulus(1'b0, rbit(), vec(3'b000, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0,
                                          2'b00, 0, 0), "memwr_wait");
        applyStimulus(1'b1, rbit(), vec(3'b000, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0,
                                        2'b00, 0, 0), "memwr");
      end
      6'b000000: begin
        applyStimulus(rbit(), rbit(), vec(fn_to_alu(fn), 1, 2'b00, 0, 0, 0, 0,
                                          0, 0, 0, 2'b00, 0, !is_legal_fn(fn)),
                      "rtype_ex");
        if (is_legal_fn(fn))
          applyStimulus(rbit(), rbit(), vec(3'b000, 0, 2'b00, 0, 0, 0, 0, 1, 1,
                                            0, 2'b00, 0, 0), "rtype_wb");
      end
      6'b000100: begin
        applyStimulus(rbit(), z, vec(3'b110, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0,
                                     2'b01, z, 0), "beq_ex");
      end
      6'b001000: begin
        applyStimulus(rbit(), rbit(), vec(3'b010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0,
                                          2'b00, 0, 0), "addi_ex");
        applyStimulus(rbit(), rbit(), vec(3'b000, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0,
                                          2'b00, 0, 0), "addi_wb");
      end
      6'b000010: begin
        applyStimulus(rbit(), rbit(), vec(3'b000, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0,
                                          2'b10, 1, 0), "jump");
      end
      default: ;
    endcase
  endtask

  initial begin
    logic [5:0] sweep_fn [5];
    logic [5:0] op;
    logic [5:0] fn;
    int         pick;

    errors    = 0;
    checks    = 0;
    exp_count = 32'd0;
    reset_n   = 1'b0;
    opcode    = 6'd0;
    funct     = 6'd0;
    zero      = 1'b0;
    mem_ready = 1'b0;

    // Hold reset for 3 cycles, release, see one IDLE cycle, then FETCH.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outs", {15'd0, obs_vec}, 32'd0);
    checkOutput("reset_count", instr_count, 32'd0);
    reset_n = 1'b1;
    #1;
    checkOutput("idle_outs", {15'd0, obs_vec}, 32'd0);
    @(posedge clk);
    #1;

    // lw with two stall cycles in both fetch and memory read.
    runInstr(6'b100011, 6'h15, 1'b0, 2, 2);

    // R-type funct sweep, then an unsupported funct.
    sweep_fn[0] = 6'b100000;
    sweep_fn[1] = 6'b100010;
    sweep_fn[2] = 6'b100100;
    sweep_fn[3] = 6'b100101;
    sweep_fn[4] = 6'b101010;
    for (int i = 0; i < 5; i++) runInstr(6'b000000, sweep_fn[i], 1'b0, 0, 0);
    runInstr(6'b000000, 6'b000000, 1'b0, 0, 0);

    // beq taken / not taken, j, addi, illegal opcode, sw with a stall.
    runInstr(6'b000100, 6'd0, 1'b1, 0, 0);
    runInstr(6'b000100, 6'd0, 1'b0, 1, 0);
    runInstr(6'b000010, 6'd0, 1'b0, 0, 0);
    runInstr(6'b001000, 6'd0, 1'b0, 0, 0);
    runInstr(6'b111111, 6'd0, 1'b0, 0, 0);
    runInstr(6'b101011, 6'd0, 1'b0, 0, 1);

    // Reset while MEMWR waits on memory: the write strobe drops at once.
    opcode = 6'b101011;
    applyStimulus(1'b1, 1'b0, vec(3'b010, 0, 2'b01, 0, 1, 0, 1, 0, 0, 0,
                                  2'b00, 1, 0), "mr_fetch");
    applyStimulus(1'b0, 1'b0, vec(3'b010, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0,
                                  2'b00, 0, 0), "mr_decode");
    applyStimulus(1'b0, 1'b0, vec(3'b010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0,
                                  2'b00, 0, 0), "mr_memadr");
    mem_ready = 1'b0;
    #1;
    checkOutput("mr_memwr_write", {31'd0, mem_write}, 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("mr_async_write", {31'd0, mem_write}, 32'd0);
    checkOutput("mr_async_outs", {15'd0, obs_vec}, 32'd0);
    checkOutput("mr_async_count", instr_count, 32'd0);
    exp_count = 32'd0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    checkOutput("mr_idle_outs", {15'd0, obs_vec}, 32'd0);

    // Preload the counter at its maximum, then one fetch wraps it to zero.
    force dut.instr_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.instr_count_q;
    exp_count = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    checkOutput("wrap_preload", instr_count, 32'hFFFF_FFFF);
    runInstr(6'b000010, 6'd0, 1'b0, 0, 0);
    checkOutput("wrap_zero", instr_count, 32'd0);

    // Random instruction mix with random stalls and branch outcomes.
    for (int n = 0; n < 60; n++) begin
      pick = $urandom_range(7, 0);
      fn   = 6'($urandom);
      case (pick)
        0: op = 6'b100011;
        1: op = 6'b101011;
        2: begin
          op = 6'b000000;
          fn = sweep_fn[$urandom_range(4, 0)];
        end
        3: begin
          op = 6'b000000;
          while (is_legal_fn(fn)) fn = 6'($urandom);
        end
        4: op = 6'b000100;
        5: op = 6'b001000;
        6: op = 6'b000010;
        default: begin
          op = 6'($urandom);
          while (is_legal_op(op)) op = 6'($urandom);
        end
      endcase
      runInstr(op, fn, rbit(), $urandom_range(2, 0), $urandom_range(2, 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
